// File: rtl/ps2_command_output.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop, then device ack.
// All outputs registered or decoded from state; device falling edges pace the data phase, with inter-edge timeout.
module ps2_command_output #(
    parameter int INHIBIT_CYCLES = 1500,
    parameter int RTS_CYCLES     = 30,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       cmd_busy,
    output logic       cmd_ack_strb,
    output logic       cmd_err_strb
);

    localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_C) + 1;

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [3:0]    bit_inc;
    logic [7:0]    data_q, data_nxt;
    logic          parity_q, parity_nxt;
    logic          clk_oe_q, clk_oe_nxt;
    logic          data_oe_q, data_oe_nxt;
    logic          ack_q, ack_nxt;
    logic          err_q, err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            data_q    <= data_nxt;
            parity_q  <= parity_nxt;
            clk_oe_q  <= clk_oe_nxt;
            data_oe_q <= data_oe_nxt;
            ack_q     <= ack_nxt;
            err_q     <= err_nxt;
        end
    end

    assign bit_inc = bit_cnt + 4'd1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        data_nxt    = data_q;
        parity_nxt  = parity_q;
        clk_oe_nxt  = clk_oe_q;
        data_oe_nxt = data_oe_q;
        ack_nxt     = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                if (cmd_valid) begin
                    data_nxt   = cmd_data;
                    parity_nxt = ~^cmd_data;
                    cnt_nxt    = '0;
                    clk_oe_nxt = 1'b1;
                    state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_nxt     = '0;
                    data_oe_nxt = 1'b1;
                    state_nxt   = RTS;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RTS: begin
                if (cnt == CW'(RTS_CYCLES - 1)) begin
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    clk_oe_nxt  = 1'b0;
                    state_nxt   = DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA, ACK: begin
                // An edge on the terminal-count cycle wins over the timeout.
                if (ps2_clk_negedge) begin
                    cnt_nxt = '0;
                    if (state == ACK) begin
                        ack_nxt   = ~ps2_data;
                        err_nxt   = ps2_data;
                        state_nxt = IDLE;
                    end else begin
                        bit_cnt_nxt = bit_inc;
                        if (bit_inc <= 4'd8) begin
                            data_oe_nxt = ~data_q[bit_inc[2:0] - 3'd1];
                        end else if (bit_inc == 4'd9) begin
                            data_oe_nxt = ~parity_q;
                        end else begin
                            data_oe_nxt = 1'b0;
                            state_nxt   = ACK;
                        end
                    end
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    cnt_nxt     = '0;
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    assign cmd_ready    = (state == IDLE);
    assign cmd_busy     = (state != IDLE);
    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign cmd_ack_strb = ack_q;
    assign cmd_err_strb = err_q;

endmodule

// File: tb/tb_ps2_command_output.sv
// Directed bench for ps2_command_output: full transfers, parity, no-ack, timeouts, reset mid-transfer.
module tb_ps2_command_output;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ps2_clk_negedge;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       cmd_busy;
    logic       cmd_ack_strb;
    logic       cmd_err_strb;

    int checks = 0;
    int errors = 0;

    ps2_command_output #(
        .INHIBIT_CYCLES(8),
        .RTS_CYCLES(4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_data(cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .ps2_clk_negedge(ps2_clk_negedge),
        .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .cmd_busy(cmd_busy),
        .cmd_ack_strb(cmd_ack_strb),
        .cmd_err_strb(cmd_err_strb)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        ps2_clk_negedge = 1'b1;
        tick();
        ps2_clk_negedge = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        int w;
        w = 0;
        while (!cmd_ready && w < 100) begin
            tick();
            w++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_wait: cmd_ready=%b, required 1 within 100 cycles", cmd_ready);
        end
        cmd_data  = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic transfer(input logic [7:0] d, input logic par_oe, input logic ack_level,
                            input logic exp_ack);
        logic exp;
        send(d);
        checks++;
        if (cmd_busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept: busy=%b ready=%b, required 1/0", cmd_busy, cmd_ready);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ps2_clk_oe !== 1'b1 || ps2_data_oe !== 1'b0) begin
                errors++;
                $display("FAIL inhibit[%0d]: clk_oe=%b data_oe=%b, required 1/0", i, ps2_clk_oe, ps2_data_oe);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ps2_clk_oe !== 1'b1 || ps2_data_oe !== 1'b1) begin
                errors++;
                $display("FAIL rts[%0d]: clk_oe=%b data_oe=%b, required 1/1", i, ps2_clk_oe, ps2_data_oe);
            end
            tick();
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
            errors++;
            $display("FAIL release: clk_oe=%b data_oe=%b, required 0/1", ps2_clk_oe, ps2_data_oe);
        end
        repeat (5) tick();
        for (int n = 1; n <= 10; n++) begin
            pulse();
            if (n <= 8)      exp = ~d[n-1];
            else if (n == 9) exp = par_oe;
            else             exp = 1'b0;
            checks++;
            if (ps2_data_oe !== exp || cmd_busy !== 1'b1) begin
                errors++;
                $display("FAIL bit%0d data 0x%02h: data_oe=%b busy=%b, required %b/1",
                         n, d, ps2_data_oe, cmd_busy, exp);
            end
            repeat (9) tick();
        end
        ps2_data = ack_level;
        pulse();
        ps2_data = 1'b1;
        checks++;
        if (cmd_ack_strb !== exp_ack || cmd_err_strb !== ~exp_ack || cmd_ready !== 1'b1 ||
            ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL ack 0x%02h: ack=%b err=%b ready=%b clk_oe=%b data_oe=%b, required %b/%b/1/0/0",
                     d, cmd_ack_strb, cmd_err_strb, cmd_ready, ps2_clk_oe, ps2_data_oe, exp_ack, ~exp_ack);
        end
        tick();
        checks++;
        if (cmd_ack_strb !== 1'b0 || cmd_err_strb !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width 0x%02h: ack=%b err=%b, required 0/0", d, cmd_ack_strb, cmd_err_strb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || cmd_busy !== 1'b0 || ps2_clk_oe !== 1'b0 ||
            ps2_data_oe !== 1'b0 || cmd_ack_strb !== 1'b0 || cmd_err_strb !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b busy=%b clk_oe=%b data_oe=%b ack=%b err=%b, required 1/0/0/0/0/0",
                     cmd_ready, cmd_busy, ps2_clk_oe, ps2_data_oe, cmd_ack_strb, cmd_err_strb);
        end
        // Edges in IDLE must not start anything.
        pulse();
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || cmd_err_strb !== 1'b0) begin
            errors++;
            $display("FAIL idle_edge: ready=%b clk_oe=%b err=%b, required 1/0/0", cmd_ready, ps2_clk_oe, cmd_err_strb);
        end
    endtask

    task automatic test_send_ed();
        transfer(8'hED, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_parity();
        transfer(8'h00, 1'b0, 1'b0, 1'b1);
        transfer(8'hFF, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_no_ack();
        transfer(8'h01, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        send(8'hFF);
        repeat (12) tick();
        checks++;
        if (ps2_clk_oe !== 1'b0 || cmd_busy !== 1'b1) begin
            errors++;
            $display("FAIL to_release: clk_oe=%b busy=%b, required 0/1", ps2_clk_oe, cmd_busy);
        end
        repeat (63) tick();
        checks++;
        if (cmd_busy !== 1'b1 || cmd_err_strb !== 1'b0) begin
            errors++;
            $display("FAIL to_early: busy=%b err=%b at 63 cycles, required 1/0", cmd_busy, cmd_err_strb);
        end
        tick();
        checks++;
        if (cmd_err_strb !== 1'b1 || cmd_ack_strb !== 1'b0 || cmd_ready !== 1'b1 ||
            ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL to_abort: err=%b ack=%b ready=%b clk_oe=%b data_oe=%b, required 1/0/1/0/0",
                     cmd_err_strb, cmd_ack_strb, cmd_ready, ps2_clk_oe, ps2_data_oe);
        end
        tick();
        checks++;
        if (cmd_err_strb !== 1'b0) begin
            errors++;
            $display("FAIL to_width: err=%b, required 0", cmd_err_strb);
        end
    endtask

    task automatic test_timeout_mid_byte();
        send(8'hA5);
        repeat (12) tick();
        for (int n = 1; n <= 3; n++) begin
            pulse();
            repeat (9) tick();
        end
        pulse();
        repeat (63) tick();
        checks++;
        if (cmd_busy !== 1'b1 || cmd_err_strb !== 1'b0) begin
            errors++;
            $display("FAIL mid_early: busy=%b err=%b, required 1/0", cmd_busy, cmd_err_strb);
        end
        tick();
        checks++;
        if (cmd_err_strb !== 1'b1 || cmd_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: err=%b ready=%b clk_oe=%b data_oe=%b, required 1/1/0/0",
                     cmd_err_strb, cmd_ready, ps2_clk_oe, ps2_data_oe);
        end
        tick();
        transfer(8'h55, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] d;
        d = 8'h34;
        send(d);
        cmd_valid = 1'b1;
        cmd_data  = 8'h12;
        repeat (15) tick();
        for (int n = 1; n <= 5; n++) begin
            pulse();
            checks++;
            if (ps2_data_oe !== ~d[n-1] || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL held_bit%0d: data_oe=%b ready=%b, required %b/0", n, ps2_data_oe, cmd_ready, ~d[n-1]);
            end
            if (n < 5) repeat (9) tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || cmd_ready !== 1'b1 ||
            cmd_ack_strb !== 1'b0 || cmd_err_strb !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: clk_oe=%b data_oe=%b ready=%b ack=%b err=%b, required 0/0/1/0/0",
                     ps2_clk_oe, ps2_data_oe, cmd_ready, cmd_ack_strb, cmd_err_strb);
        end
        rst = 1'b0;
        // cmd_valid is still held with 0x12; it is taken on the first idle edge.
        transfer(8'h12, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst             = 1'b1;
        cmd_data        = 8'h00;
        cmd_valid       = 1'b0;
        ps2_clk_negedge = 1'b0;
        ps2_data        = 1'b1;
        test_reset();
        test_send_ed();
        test_parity();
        test_no_ack();
        test_timeout();
        test_timeout_mid_byte();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
